// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer slice.
package fetch_sequencer_pkg;

   localparam int PC_W = 16;

   typedef logic [PC_W-1:0] pc_t;

   localparam pc_t RESET_PC_DEF = 16'h0000;
   localparam pc_t PC_STEP_DEF  = 16'h0002;

   localparam logic [1:0] FETCH_IDLE  = 2'd0;
   localparam logic [1:0] FETCH_FETCH = 2'd1;
   localparam logic [1:0] FETCH_HOLD  = 2'd2;
   localparam logic [1:0] FETCH_HALT  = 2'd3;

   // Instruction addresses are halfword aligned; bit 0 is forced low.
   function automatic pc_t align_pc(input pc_t a);
      return a & ~pc_t'(1);
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction memory request/response bus.
interface fetch_sequencer_if;
   import fetch_sequencer_pkg::*;

   logic imem_req;
   pc_t  imem_addr;
   logic imem_rdy;
   pc_t  imem_data;

   modport master (output imem_req, output imem_addr, input imem_rdy, input imem_data);
   modport slave  (input imem_req, input imem_addr, output imem_rdy, output imem_data);

endinterface

// File: rtl/carry_lookahead.sv
// Generic carry-lookahead adder/subtractor.
module carry_lookahead #(
   parameter int W = 16
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_sub,
   output logic [W-1:0] o_sum,
   output logic         o_ovf
);

   logic [W-1:0] w_b;
   logic [W-1:0] w_g;
   logic [W-1:0] w_p;
   logic [W:0]   w_c;

   assign w_b = i_b ^ {W{i_sub}};
   assign w_g = i_a & w_b;
   assign w_p = i_a ^ w_b;

   // Carry chain from generate/propagate terms.
   always_comb begin
      w_c    = '0;
      w_c[0] = i_sub;
      for (int i = 0; i < W; i++) begin
         w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
      end
   end

   assign o_sum = w_p ^ w_c[W-1:0];
   assign o_ovf = w_c[W] ^ w_c[W-1];

endmodule

// File: rtl/fetch_sequencer_pc_incr.sv
// pc_incr: next sequential PC and the decode-side instr_pc + step.
module fetch_sequencer_pc_incr
   import fetch_sequencer_pkg::*;
#(
   parameter pc_t PC_STEP = PC_STEP_DEF
) (
   input  pc_t i_pc,
   input  pc_t i_instr_pc,
   output pc_t o_pc_next,
   output pc_t o_instr_pc_plus
);

   // Signed overflow has no meaning for addresses; wrap is silent.
   logic w_ovf_unused_pc;
   logic w_ovf_unused_ipc;

   carry_lookahead #(.W(PC_W)) u_add_pc (
      .i_a   (i_pc),
      .i_b   (PC_STEP),
      .i_sub (1'b0),
      .o_sum (o_pc_next),
      .o_ovf (w_ovf_unused_pc)
   );

   carry_lookahead #(.W(PC_W)) u_add_ipc (
      .i_a   (i_instr_pc),
      .i_b   (PC_STEP),
      .i_sub (1'b0),
      .o_sum (o_instr_pc_plus),
      .o_ovf (w_ovf_unused_ipc)
   );

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues one imem request at a time and
// holds the returned word for decode.
//
// state | meaning
// IDLE  | first cycle after reset, no request
// FETCH | imem_req high at pc_q, waiting for imem_rdy
// HOLD  | instruction presented to decode, waiting for it to be consumed
// HALT  | HLT retired; terminal until reset
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter pc_t RESET_PC = RESET_PC_DEF,
   parameter pc_t PC_STEP  = PC_STEP_DEF
) (
   input  logic               clk,
   input  logic               rst,
   fetch_sequencer_if.master  imem,
   input  logic               i_stall,
   input  logic               i_halt_in,
   input  logic               i_redirect_valid,
   input  pc_t                i_redirect_pc,
   output pc_t                o_instr,
   output logic               o_instr_valid,
   output pc_t                o_instr_pc,
   output pc_t                o_pc_plus2,
   output logic               o_halted
);

   logic [1:0] r_state;
   pc_t        r_pc;
   pc_t        r_instr;
   pc_t        r_instr_pc;
   logic       r_instr_valid;
   logic       r_halted;

   logic [1:0] w_state_nxt;
   pc_t        w_pc_nxt;
   pc_t        w_instr_nxt;
   pc_t        w_instr_pc_nxt;
   logic       w_instr_valid_nxt;
   logic       w_halted_nxt;
   pc_t        w_pc_inc;

   fetch_sequencer_pc_incr #(.PC_STEP(PC_STEP)) u_pc_incr (
      .i_pc            (r_pc),
      .i_instr_pc      (r_instr_pc),
      .o_pc_next       (w_pc_inc),
      .o_instr_pc_plus (o_pc_plus2)
   );

   assign imem.imem_req  = (r_state == FETCH_FETCH);
   assign imem.imem_addr = r_pc;
   assign o_instr        = r_instr;
   assign o_instr_valid  = r_instr_valid;
   assign o_instr_pc     = r_instr_pc;
   assign o_halted       = r_halted;

   // Next-state logic; redirect outranks halt, halt outranks stall.
   always_comb begin
      w_state_nxt       = r_state;
      w_pc_nxt          = r_pc;
      w_instr_nxt       = r_instr;
      w_instr_pc_nxt    = r_instr_pc;
      w_instr_valid_nxt = r_instr_valid;
      w_halted_nxt      = r_halted;
      case (r_state)
         FETCH_IDLE: begin
            w_state_nxt = FETCH_FETCH;
         end
         FETCH_FETCH: begin
            if (i_redirect_valid) begin
               // Any response arriving alongside the redirect is dropped.
               w_pc_nxt          = align_pc(i_redirect_pc);
               w_instr_valid_nxt = 1'b0;
            end else if (imem.imem_rdy) begin
               w_instr_nxt       = imem.imem_data;
               w_instr_pc_nxt    = r_pc;
               w_pc_nxt          = w_pc_inc;
               w_instr_valid_nxt = 1'b1;
               w_state_nxt       = FETCH_HOLD;
            end
         end
         FETCH_HOLD: begin
            if (i_redirect_valid) begin
               w_pc_nxt          = align_pc(i_redirect_pc);
               w_instr_valid_nxt = 1'b0;
               w_state_nxt       = FETCH_FETCH;
            end else if (i_halt_in) begin
               w_instr_valid_nxt = 1'b0;
               w_halted_nxt      = 1'b1;
               w_state_nxt       = FETCH_HALT;
            end else if (!i_stall) begin
               w_instr_valid_nxt = 1'b0;
               w_state_nxt       = FETCH_FETCH;
            end
         end
         default: begin
            w_state_nxt = FETCH_HALT;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= FETCH_IDLE;
         r_pc          <= RESET_PC;
         r_instr       <= '0;
         r_instr_pc    <= '0;
         r_instr_valid <= 1'b0;
         r_halted      <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_instr       <= w_instr_nxt;
         r_instr_pc    <= w_instr_pc_nxt;
         r_instr_valid <= w_instr_valid_nxt;
         r_halted      <= w_halted_nxt;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer with a wait-state memory model
// and a scoreboard of captured instructions.
module tb_fetch_sequencer;
   import fetch_sequencer_pkg::*;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        halt_in = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic [15:0] instr;
   logic        instr_valid;
   logic [15:0] instr_pc;
   logic [15:0] pc_plus2;
   logic        halted;

   int   n_checks = 0;
   int   n_fail = 0;
   int   mem_wait = 0;
   int   mem_cnt = 0;
   logic prev_valid = 1'b0;
   exp_t sb[$];

   fetch_sequencer_if mif ();

   fetch_sequencer dut (
      .clk              (clk),
      .rst              (rst),
      .imem             (mif),
      .i_stall          (stall),
      .i_halt_in        (halt_in),
      .i_redirect_valid (redirect_valid),
      .i_redirect_pc    (redirect_pc),
      .o_instr          (instr),
      .o_instr_valid    (instr_valid),
      .o_instr_pc       (instr_pc),
      .o_pc_plus2       (pc_plus2),
      .o_halted         (halted)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   // One clock: record what the DUT should capture, step, pop/compare the
   // scoreboard on a new instr_valid, then drive the memory response.
   task automatic cycle();
      exp_t        e;
      logic [15:0] p2;
      if (!rst && mif.imem_req && mif.imem_rdy && !redirect_valid)
         sb.push_back('{mem_word(mif.imem_addr), mif.imem_addr});
      @(posedge clk);
      #1;
      if (rst) begin
         sb.delete();
         prev_valid = 1'b0;
      end else begin
         if (instr_valid && !prev_valid) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL sb_pop: instr_valid rose with nothing expected (instr=%h pc=%h)", instr, instr_pc);
            end else begin
               e  = sb.pop_front();
               p2 = e.pc + 16'd2;
               if (instr !== e.instr || instr_pc !== e.pc || pc_plus2 !== p2) begin
                  n_fail++;
                  $display("FAIL sb_instr: got instr=%h pc=%h plus2=%h, expected instr=%h pc=%h plus2=%h",
                           instr, instr_pc, pc_plus2, e.instr, e.pc, p2);
               end
            end
         end
         prev_valid = instr_valid;
      end
      if (mif.imem_req) begin
         if (mem_cnt >= mem_wait) begin
            mif.imem_rdy  = 1'b1;
            mif.imem_data = mem_word(mif.imem_addr);
            mem_cnt       = 0;
         end else begin
            mif.imem_rdy  = 1'b0;
            mif.imem_data = 16'hDEAD;
            mem_cnt++;
         end
      end else begin
         mif.imem_rdy  = 1'b0;
         mif.imem_data = 16'hDEAD;
         mem_cnt       = 0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      stall = 1'b0; halt_in = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
      mem_wait = 0; mem_cnt = 0;
      mif.imem_rdy = 1'b0; mif.imem_data = 16'hDEAD;
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b1;
      cycle();
      n_checks++; if (mif.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", mif.imem_req); end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
      n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b expected 0", halted); end
      n_checks++; if (instr !== 16'h0000 || instr_pc !== 16'h0000) begin n_fail++; $display("FAIL rst_instr: got instr=%h pc=%h expected 0000 0000", instr, instr_pc); end
      n_checks++; if (mif.imem_addr !== 16'h0000 || pc_plus2 !== 16'h0002) begin n_fail++; $display("FAIL rst_pc: got addr=%h plus2=%h expected 0000 0002", mif.imem_addr, pc_plus2); end
      rst = 1'b0;
      cycle();
      n_checks++; if (mif.imem_req !== 1'b1) begin n_fail++; $display("FAIL idle_exit: got req=%b expected 1", mif.imem_req); end
   endtask

   task automatic test_sequential();
      logic [15:0] a;
      do_reset();
      cycle();
      for (int i = 0; i < 3; i++) begin
         a = 16'(2 * i);
         n_checks++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== a) begin n_fail++; $display("FAIL seq_addr: got req=%b addr=%h expected 1 %h", mif.imem_req, mif.imem_addr, a); end
         cycle();
         n_checks++; if (instr_valid !== 1'b1 || mif.imem_req !== 1'b0 || pc_plus2 !== a + 16'd2) begin n_fail++; $display("FAIL seq_hold: got valid=%b req=%b plus2=%h expected 1 0 %h", instr_valid, mif.imem_req, pc_plus2, a + 16'd2); end
         cycle();
         n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL seq_pulse: got valid=%b expected 0", instr_valid); end
      end
   endtask

   task automatic test_mem_wait();
      do_reset();
      mem_wait = 3;
      cycle();
      for (int k = 0; k < 3; k++) begin
         n_checks++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== 16'h0000 || instr_valid !== 1'b0 || instr !== 16'h0000) begin
            n_fail++; $display("FAIL wait_stable: got req=%b addr=%h valid=%b instr=%h expected 1 0000 0 0000", mif.imem_req, mif.imem_addr, instr_valid, instr);
         end
         cycle();
      end
      n_checks++; if (mif.imem_rdy !== 1'b1 || mif.imem_req !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL wait_rdy: got rdy=%b req=%b valid=%b expected 1 1 0", mif.imem_rdy, mif.imem_req, instr_valid); end
      cycle();
      n_checks++; if (instr_valid !== 1'b1 || instr !== mem_word(16'h0000)) begin n_fail++; $display("FAIL wait_capture: got valid=%b instr=%h expected 1 %h", instr_valid, instr, mem_word(16'h0000)); end
   endtask

   task automatic test_stall();
      do_reset();
      cycle();
      cycle();
      stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cycle();
         n_checks++; if (instr_valid !== 1'b1 || instr !== mem_word(16'h0000) || instr_pc !== 16'h0000 || mif.imem_req !== 1'b0) begin
            n_fail++; $display("FAIL stall_hold: got valid=%b instr=%h pc=%h req=%b expected 1 %h 0000 0", instr_valid, instr, instr_pc, mif.imem_req, mem_word(16'h0000));
         end
      end
      stall = 1'b0;
      cycle();
      n_checks++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== 16'h0002 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: got req=%b addr=%h valid=%b expected 1 0002 0", mif.imem_req, mif.imem_addr, instr_valid); end
   endtask

   task automatic test_redirect();
      do_reset();
      cycle();
      redirect_valid = 1'b1; redirect_pc = 16'h0101;
      cycle();
      redirect_valid = 1'b0;
      n_checks++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== 16'h0100 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_fetch: got req=%b addr=%h valid=%b expected 1 0100 0", mif.imem_req, mif.imem_addr, instr_valid); end
      cycle();
      n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0100) begin n_fail++; $display("FAIL redir_target: got valid=%b pc=%h expected 1 0100", instr_valid, instr_pc); end
      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0200;
      cycle();
      redirect_valid = 1'b0; stall = 1'b0;
      n_checks++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== 16'h0200 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_hold: got req=%b addr=%h valid=%b expected 1 0200 0", mif.imem_req, mif.imem_addr, instr_valid); end
   endtask

   task automatic test_halt();
      int reqs;
      do_reset();
      cycle();
      for (int i = 0; i < 4; i++) begin
         cycle();
         if (i < 3) cycle();
      end
      n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0006) begin n_fail++; $display("FAIL halt_setup: got valid=%b pc=%h expected 1 0006", instr_valid, instr_pc); end
      halt_in = 1'b1;
      cycle();
      halt_in = 1'b0;
      n_checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || mif.imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_enter: got halted=%b valid=%b req=%b expected 1 0 0", halted, instr_valid, mif.imem_req); end
      redirect_valid = 1'b1; redirect_pc = 16'h0040;
      cycle();
      cycle();
      redirect_valid = 1'b0;
      n_checks++; if (halted !== 1'b1 || mif.imem_addr !== 16'h0008) begin n_fail++; $display("FAIL halt_redirect: got halted=%b addr=%h expected 1 0008", halted, mif.imem_addr); end
      reqs = 0;
      for (int k = 0; k < 4; k++) begin
         cycle();
         if (mif.imem_req) reqs++;
      end
      n_checks++; if (reqs != 0) begin n_fail++; $display("FAIL halt_noreq: got %0d request cycles expected 0", reqs); end
   endtask

   task automatic test_wrap_reset();
      do_reset();
      cycle();
      redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
      cycle();
      redirect_valid = 1'b0;
      n_checks++; if (mif.imem_addr !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_addr: got %h expected fffe", mif.imem_addr); end
      cycle();
      n_checks++; if (instr_pc !== 16'hFFFE || pc_plus2 !== 16'h0000) begin n_fail++; $display("FAIL wrap_plus2: got pc=%h plus2=%h expected fffe 0000", instr_pc, pc_plus2); end
      cycle();
      n_checks++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_next: got req=%b addr=%h expected 1 0000", mif.imem_req, mif.imem_addr); end
      redirect_valid = 1'b1; redirect_pc = 16'h0300;
      cycle();
      redirect_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_checks++; if (mif.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_async: got req=%b expected 0", mif.imem_req); end
      cycle();
      rst = 1'b0;
      cycle();
      n_checks++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== 16'h0000 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_restart: got req=%b addr=%h valid=%b expected 1 0000 0", mif.imem_req, mif.imem_addr, instr_valid); end
      cycle();
      n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0000) begin n_fail++; $display("FAIL rst_refetch: got valid=%b pc=%h expected 1 0000", instr_valid, instr_pc); end
   endtask

   initial begin
      mif.imem_rdy  = 1'b0;
      mif.imem_data = 16'hDEAD;
      test_reset();
      test_sequential();
      test_mem_wait();
      test_stall();
      test_redirect();
      test_halt();
      test_wrap_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
